// File: rtl/circ_buf_ptr_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : buf_pkg
// Brief    : Shared defaults, width helpers and wrapped pointer arithmetic
//            for the circular column buffer controller.
// Revision : 1.0 - initial release
// ============================================================================
package buf_pkg;

    localparam int DEF_COLUMNS   = 32;
    localparam int DEF_PAR_WRITE = 4;
    localparam int DEF_PAR_READ  = 2;

    function automatic int addr_width(input int columns);
        return $clog2(columns);
    endfunction

    function automatic int cnt_width(input int columns);
        return $clog2(columns + 1);
    endfunction

    // ptr < columns and inc <= columns, so one conditional subtract wraps it
    function automatic int unsigned mod_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned columns);
        int unsigned sum;
        sum = ptr + inc;
        return (sum >= columns) ? (sum - columns) : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/circ_buf_ptr_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : circ_buf_ptr_ctrl_if
// Brief    : Write/read burst handshake and buffer-port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface circ_buf_ptr_ctrl_if
    import buf_pkg::*;
#(
    parameter int COLUMNS   = DEF_COLUMNS,
    parameter int PAR_WRITE = DEF_PAR_WRITE,
    parameter int PAR_READ  = DEF_PAR_READ
);
    localparam int AW  = addr_width(COLUMNS);
    localparam int CW  = cnt_width(COLUMNS);
    localparam int WNW = $clog2(PAR_WRITE + 1);
    localparam int RNW = $clog2(PAR_READ + 1);

    logic                      wr_req;
    logic [WNW-1:0]            wr_num;
    logic                      wr_ready;
    logic [PAR_WRITE*AW-1:0]   waddr;
    logic [PAR_WRITE-1:0]      wen;
    logic                      rd_req;
    logic [RNW-1:0]            rd_num;
    logic                      rd_valid;
    logic [PAR_READ*AW-1:0]    raddr;
    logic [PAR_READ-1:0]       ren;
    logic [CW-1:0]             count;
    logic                      full;
    logic                      empty;

    modport master (
        output wr_req, wr_num, rd_req, rd_num,
        input  wr_ready, waddr, wen, rd_valid, raddr, ren, count, full, empty
    );

    modport slave (
        input  wr_req, wr_num, rd_req, rd_num,
        output wr_ready, waddr, wen, rd_valid, raddr, ren, count, full, empty
    );

endinterface
`default_nettype wire

// File: rtl/circ_buf_ptr_ctrl_lane_addr_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lane_addr_gen
// Brief    : Per-lane wrapped addresses and burst-length lane enables.
// Revision : 1.0 - initial release
// ============================================================================
module lane_addr_gen
    import buf_pkg::*;
#(
    parameter  int COLUMNS = DEF_COLUMNS,
    parameter  int LANES   = DEF_PAR_WRITE,
    parameter  int NW      = $clog2(LANES + 1),
    localparam int AW      = addr_width(COLUMNS)
) (
    input  logic [AW-1:0]       base,
    input  logic [NW-1:0]       num,
    input  logic                fire,
    output logic [LANES*AW-1:0] addr,
    output logic [LANES-1:0]    en
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int unsigned OFS = i;
        // Address is driven on every lane; only the enable depends on num
        assign addr[i*AW +: AW] = AW'(mod_add(32'(base), OFS, COLUMNS));
        assign en[i]            = fire && (32'(num) > OFS);
    end

endmodule
`default_nettype wire

// File: rtl/circ_buf_ptr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : circ_buf_ptr_ctrl
// Brief    : Pointer/occupancy controller for a circular column buffer.
// Revision : 1.0 - initial release
// ============================================================================
module circ_buf_ptr_ctrl
    import buf_pkg::*;
#(
    parameter int COLUMNS   = DEF_COLUMNS,
    parameter int PAR_WRITE = DEF_PAR_WRITE,
    parameter int PAR_READ  = DEF_PAR_READ
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    circ_buf_ptr_ctrl_if.slave bus
);

    localparam int AW  = addr_width(COLUMNS);
    localparam int CW  = cnt_width(COLUMNS);
    localparam int WNW = $clog2(PAR_WRITE + 1);
    localparam int RNW = $clog2(PAR_READ + 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    int unsigned w_wr_len;
    int unsigned w_rd_len;
    int unsigned w_occ;
    logic        w_wr_ready;
    logic        w_rd_valid;
    logic        w_wr_fire;
    logic        w_rd_fire;

    always_comb begin
        w_wr_len = 32'(bus.wr_num);
        w_rd_len = 32'(bus.rd_num);
        w_occ    = 32'(cnt_q);

        // Readiness sees only the current occupancy: no same-cycle bypass
        w_wr_ready = (w_wr_len >= 32'd1) && (w_wr_len <= PAR_WRITE)
                     && ((COLUMNS - w_occ) >= w_wr_len);
        w_rd_valid = (w_rd_len >= 32'd1) && (w_rd_len <= PAR_READ)
                     && (w_occ >= w_rd_len);

        w_wr_fire = bus.wr_req && w_wr_ready && !flush;
        w_rd_fire = bus.rd_req && w_rd_valid && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (w_wr_fire) begin
                wr_ptr_d = AW'(mod_add(32'(wr_ptr_q), w_wr_len, COLUMNS));
            end
            if (w_rd_fire) begin
                rd_ptr_d = AW'(mod_add(32'(rd_ptr_q), w_rd_len, COLUMNS));
            end
            cnt_d = CW'(w_occ + (w_wr_fire ? w_wr_len : 32'd0)
                              - (w_rd_fire ? w_rd_len : 32'd0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    lane_addr_gen #(
        .COLUMNS (COLUMNS),
        .LANES   (PAR_WRITE),
        .NW      (WNW)
    ) u_wr_lanes (
        .base (wr_ptr_q),
        .num  (bus.wr_num),
        .fire (w_wr_fire),
        .addr (bus.waddr),
        .en   (bus.wen)
    );

    lane_addr_gen #(
        .COLUMNS (COLUMNS),
        .LANES   (PAR_READ),
        .NW      (RNW)
    ) u_rd_lanes (
        .base (rd_ptr_q),
        .num  (bus.rd_num),
        .fire (w_rd_fire),
        .addr (bus.raddr),
        .en   (bus.ren)
    );

    assign bus.wr_ready = w_wr_ready;
    assign bus.rd_valid = w_rd_valid;
    assign bus.count    = cnt_q;
    assign bus.full     = (cnt_q == CW'(COLUMNS));
    assign bus.empty    = (cnt_q == '0);

endmodule
`default_nettype wire
